// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared RV32I decode definitions for the decode stage:
//   - opcode_e    : RV32I major opcodes (instruction bits [6:0])
//   - imm_type_e  : immediate encoding formats
//   - NOP_INSTR   : canonical NOP (addi x0, x0, 0)
//   - imm_type_of : maps an opcode to its immediate format
// -----------------------------------------------------------------------------
package decode_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // R-type and unrecognised opcodes carry no immediate.
  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    imm_type_e t;
    t = IMM_NONE;
    case (opcode)
      OP_JALR, OP_LOAD, OP_IMM,
      OP_FENCE, OP_SYSTEM:  t = IMM_I;
      OP_STORE:             t = IMM_S;
      OP_BRANCH:            t = IMM_B;
      OP_LUI, OP_AUIPC:     t = IMM_U;
      OP_JAL:               t = IMM_J;
      default:              t = IMM_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
// 32 x 32-bit integer register file, two combinational read ports, one
// synchronous write port. x0 is hard-wired to zero.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset (clears all)
//   i_wren/i_waddr/i_wdata  write-back port (writes to x0 ignored)
//   i_raddr1/i_raddr2       read addresses
//   o_rdata1/o_rdata2       read data (optionally bypassed from the write port)
// -----------------------------------------------------------------------------
module regfile #(
  parameter int BYPASS_EN = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wren,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);

  logic [31:0] r_regs [32];
  logic        w_wr_ok;

  assign w_wr_ok = i_wren && (i_waddr != 5'd0);

  // A write presented on the reset cycle is dropped: reset wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Bypass lets the decode stage see a value being written back this cycle,
  // which would otherwise only become visible one cycle later.
  always_comb begin
    o_rdata1 = r_regs[i_raddr1];
    if (i_raddr1 == 5'd0) begin
      o_rdata1 = '0;
    end else if ((BYPASS_EN != 0) && w_wr_ok && (i_waddr == i_raddr1)) begin
      o_rdata1 = i_wdata;
    end
  end

  always_comb begin
    o_rdata2 = r_regs[i_raddr2];
    if (i_raddr2 == 5'd0) begin
      o_rdata2 = '0;
    end else if ((BYPASS_EN != 0) && w_wr_ok && (i_waddr == i_raddr2)) begin
      o_rdata2 = i_wdata;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// RV32I instruction-decode stage: IF/ID pipeline register, register-file read,
// immediate generation and load-use hazard detection.
// Ports:
//   i_clk, i_rst                         clock, synchronous active-high reset
//   i_pc_cur/i_pc_four/i_instruct        fetch-stage PC, PC+4, instruction
//   i_prediction                         fetch-stage branch prediction bit
//   i_stall                              hold IF/ID (external stall)
//   i_flush                              squash IF/ID (mispredict redirect)
//   i_rd_wren/i_rd_addr/i_rd_data        write-back port into the register file
//   i_ex_mem_rden/i_ex_rd_addr           load currently in EX and its rd
//   o_pc_cur/o_pc_four/o_instruct/o_prediction  registered IF/ID contents
//   o_rs1_addr/o_rs2_addr/o_rd_addr      instruction register fields
//   o_rs1_data/o_rs2_data/o_imm          operands and sign-extended immediate
//   o_valid                              decoded instruction valid for ID/EX
//   o_pc_enable                          fetch PC enable
//   o_load_use                           load-use hazard detected
//
// Flow control: o_valid qualifies the decode outputs for capture by ID/EX in
// the same cycle; there is no back-pressure from ID/EX. When o_load_use is
// high, o_valid drops (a bubble goes downstream), IF/ID holds and o_pc_enable
// drops so the same instruction re-issues once the load has left EX. i_flush
// overrides the hazard hold and re-enables fetch.
// -----------------------------------------------------------------------------
module decode_stage
  import decode_pkg::*;
#(
  parameter int BYPASS_EN = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc_cur,
  input  logic [31:0] i_pc_four,
  input  logic [31:0] i_instruct,
  input  logic        i_prediction,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_rd_wren,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd_data,
  input  logic        i_ex_mem_rden,
  input  logic [4:0]  i_ex_rd_addr,
  output logic [31:0] o_pc_cur,
  output logic [31:0] o_pc_four,
  output logic [31:0] o_instruct,
  output logic        o_prediction,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  output logic [31:0] o_imm,
  output logic        o_valid,
  output logic        o_pc_enable,
  output logic        o_load_use
);

  logic [31:0] r_pc_cur;
  logic [31:0] r_pc_four;
  logic [31:0] r_instruct;
  logic        r_prediction;
  logic        r_valid;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_rs1_used;
  logic        w_rs2_used;
  logic        w_load_use;
  imm_type_e   w_imm_type;
  logic [31:0] w_imm;

  // IF/ID register: reset > flush > hold > load.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_pc_cur     <= '0;
      r_pc_four    <= '0;
      r_instruct   <= NOP_INSTR;
      r_prediction <= 1'b0;
      r_valid      <= 1'b0;
    end else if (i_stall || w_load_use) begin
      r_pc_cur     <= r_pc_cur;
      r_pc_four    <= r_pc_four;
      r_instruct   <= r_instruct;
      r_prediction <= r_prediction;
      r_valid      <= r_valid;
    end else begin
      r_pc_cur     <= i_pc_cur;
      r_pc_four    <= i_pc_four;
      r_instruct   <= i_instruct;
      r_prediction <= i_prediction;
      r_valid      <= 1'b1;
    end
  end

  assign w_opcode = r_instruct[6:0];
  assign w_rs1    = r_instruct[19:15];
  assign w_rs2    = r_instruct[24:20];

  // Bits [19:15] of LUI/AUIPC/JAL are immediate, not a register.
  always_comb begin
    w_rs1_used = 1'b1;
    w_rs2_used = 1'b0;
    case (w_opcode)
      OP_LUI, OP_AUIPC, OP_JAL:    w_rs1_used = 1'b0;
      default:                     w_rs1_used = 1'b1;
    endcase
    case (w_opcode)
      OP_REG, OP_STORE, OP_BRANCH: w_rs2_used = 1'b1;
      default:                     w_rs2_used = 1'b0;
    endcase
  end

  assign w_load_use = i_ex_mem_rden && r_valid && (i_ex_rd_addr != 5'd0) &&
                      ((w_rs1_used && (i_ex_rd_addr == w_rs1)) ||
                       (w_rs2_used && (i_ex_rd_addr == w_rs2)));

  assign w_imm_type = imm_type_of(w_opcode);

  always_comb begin
    w_imm = '0;
    case (w_imm_type)
      IMM_I: w_imm = {{21{r_instruct[31]}}, r_instruct[30:20]};
      IMM_S: w_imm = {{21{r_instruct[31]}}, r_instruct[30:25], r_instruct[11:7]};
      IMM_B: w_imm = {{20{r_instruct[31]}}, r_instruct[7], r_instruct[30:25],
                      r_instruct[11:8], 1'b0};
      IMM_U: w_imm = {r_instruct[31:12], 12'b0};
      IMM_J: w_imm = {{12{r_instruct[31]}}, r_instruct[19:12], r_instruct[20],
                      r_instruct[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  regfile #(
    .BYPASS_EN (BYPASS_EN)
  ) u_regfile (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wren   (i_rd_wren),
    .i_waddr  (i_rd_addr),
    .i_wdata  (i_rd_data),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (o_rs1_data),
    .o_rdata2 (o_rs2_data)
  );

  assign o_pc_cur     = r_pc_cur;
  assign o_pc_four    = r_pc_four;
  assign o_instruct   = r_instruct;
  assign o_prediction = r_prediction;
  assign o_rs1_addr   = w_rs1;
  assign o_rs2_addr   = w_rs2;
  assign o_rd_addr    = r_instruct[11:7];
  assign o_imm        = w_imm;
  assign o_valid      = r_valid && !w_load_use;
  assign o_load_use   = w_load_use;
  assign o_pc_enable  = !i_stall && (!w_load_use || i_flush);

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Directed self-checking bench for decode_stage with hand-computed vectors.
// Inputs change 1 ns after a rising edge; outputs are checked after a short
// settle, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADD_1_5_0 = 32'h0002_80B3; // add  x1,x5,x0
  localparam logic [31:0] ADD_1_5_6 = 32'h0062_80B3; // add  x1,x5,x6
  localparam logic [31:0] ADDI_2_7  = 32'hFFF3_8113; // addi x2,x7,-1
  localparam logic [31:0] ADD_4_3_3 = 32'h0031_8233; // add  x4,x3,x3
  localparam logic [31:0] SW_2_M4_1 = 32'hFE20_AE23; // sw   x2,-4(x1)
  localparam logic [31:0] LUI_5     = 32'h1234_52B7; // lui  x5,0x12345
  localparam logic [31:0] BEQ_1_2_8 = 32'h0020_8463; // beq  x1,x2,+8
  localparam logic [31:0] JAL_1_M4  = 32'hFFDF_F0EF; // jal  x1,-4

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] pc_cur, pc_four, instruct, rd_data;
  logic        prediction, stall, flush, rd_wren, ex_mem_rden;
  logic [4:0]  rd_addr, ex_rd_addr;

  logic [31:0] o_pc_cur, o_pc_four, o_instruct, o_rs1_data, o_rs2_data, o_imm;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic        o_prediction, o_valid, o_pc_enable, o_load_use;

  decode_stage #(.BYPASS_EN(1)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pc_cur      (pc_cur),
    .i_pc_four     (pc_four),
    .i_instruct    (instruct),
    .i_prediction  (prediction),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_rd_wren     (rd_wren),
    .i_rd_addr     (rd_addr),
    .i_rd_data     (rd_data),
    .i_ex_mem_rden (ex_mem_rden),
    .i_ex_rd_addr  (ex_rd_addr),
    .o_pc_cur      (o_pc_cur),
    .o_pc_four     (o_pc_four),
    .o_instruct    (o_instruct),
    .o_prediction  (o_prediction),
    .o_rs1_addr    (o_rs1_addr),
    .o_rs2_addr    (o_rs2_addr),
    .o_rd_addr     (o_rd_addr),
    .o_rs1_data    (o_rs1_data),
    .o_rs2_data    (o_rs2_data),
    .o_imm         (o_imm),
    .o_valid       (o_valid),
    .o_pc_enable   (o_pc_enable),
    .o_load_use    (o_load_use)
  );

  // scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_fetch(input logic [31:0] pc, input logic [31:0] ins, input logic pred);
    pc_cur     = pc;
    pc_four    = pc + 32'd4;
    instruct   = ins;
    prediction = pred;
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    rd_wren = en;
    rd_addr = addr;
    rd_data = data;
  endtask

  task automatic drive_ex(input logic en, input logic [4:0] addr);
    ex_mem_rden = en;
    ex_rd_addr  = addr;
  endtask

  logic [31:0] stream_tbl [4];

  initial begin
    stall = 1'b0;
    flush = 1'b0;
    drive_fetch(32'h40, ADD_1_5_0, 1'b1);
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_ex(1'b0, 5'd0);

    // reset overrides a pending load
    tick();
    tick();
    settle();
    check("rst_instruct", o_instruct, NOP);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_pc_cur", o_pc_cur, 32'h0);
    check("rst_pc_four", o_pc_four, 32'h0);
    check("rst_pred", {31'b0, o_prediction}, 32'd0);
    check("rst_load_use", {31'b0, o_load_use}, 32'd0);
    check("rst_pc_en", {31'b0, o_pc_enable}, 32'd1);
    stall = 1'b1;
    settle();
    check("rst_pc_en_stall", {31'b0, o_pc_enable}, 32'd0);
    stall = 1'b0;
    rst   = 1'b0;

    // x0 write ignored, x5 written, then add x1,x5,x0
    drive_fetch(32'h0, NOP, 1'b0);
    drive_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    drive_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_fetch(32'h100, ADD_1_5_0, 1'b1);
    tick();
    settle();
    check("add_instruct", o_instruct, ADD_1_5_0);
    check("add_pc_cur", o_pc_cur, 32'h100);
    check("add_pc_four", o_pc_four, 32'h104);
    check("add_pred", {31'b0, o_prediction}, 32'd1);
    check("add_valid", {31'b0, o_valid}, 32'd1);
    check("add_rs1_addr", {27'b0, o_rs1_addr}, 32'd5);
    check("add_rs2_addr", {27'b0, o_rs2_addr}, 32'd0);
    check("add_rd_addr", {27'b0, o_rd_addr}, 32'd1);
    check("add_rs1_data", o_rs1_data, 32'hDEAD_BEEF);
    check("x0_read", o_rs2_data, 32'h0);
    check("add_imm_r", o_imm, 32'h0);
    drive_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    settle();
    check("x0_no_bypass", o_rs2_data, 32'h0);
    drive_wb(1'b0, 5'd0, 32'h0);

    // same-cycle write-back bypass into addi x2,x7,-1
    drive_fetch(32'h104, ADDI_2_7, 1'b0);
    tick();
    drive_wb(1'b1, 5'd7, 32'h0000_1234);
    settle();
    check("byp_rs1_data", o_rs1_data, 32'h0000_1234);
    check("byp_imm_i", o_imm, 32'hFFFF_FFFF);
    check("byp_rd_addr", {27'b0, o_rd_addr}, 32'd2);
    stall = 1'b1;
    settle();
    check("stall_pc_en", {31'b0, o_pc_enable}, 32'd0);
    tick();
    drive_wb(1'b0, 5'd0, 32'h0);
    settle();
    check("stall_hold_instr", o_instruct, ADDI_2_7);
    check("stall_hold_pc", o_pc_cur, 32'h104);
    check("x7_stored", o_rs1_data, 32'h0000_1234);
    stall = 1'b0;

    // load-use: load x3 in EX, add x4,x3,x3 in ID
    drive_fetch(32'h200, ADD_4_3_3, 1'b0);
    tick();
    drive_ex(1'b1, 5'd3);
    drive_fetch(32'h204, SW_2_M4_1, 1'b0);
    settle();
    check("lu_flag", {31'b0, o_load_use}, 32'd1);
    check("lu_valid", {31'b0, o_valid}, 32'd0);
    check("lu_pc_en", {31'b0, o_pc_enable}, 32'd0);
    tick();
    drive_ex(1'b0, 5'd0);
    settle();
    check("lu_reissue_instr", o_instruct, ADD_4_3_3);
    check("lu_reissue_pc", o_pc_cur, 32'h200);
    check("lu_reissue_valid", {31'b0, o_valid}, 32'd1);
    check("lu_clear_flag", {31'b0, o_load_use}, 32'd0);
    check("lu_clear_pc_en", {31'b0, o_pc_enable}, 32'd1);
    drive_ex(1'b1, 5'd0);
    settle();
    check("lu_rd_x0", {31'b0, o_load_use}, 32'd0);
    drive_ex(1'b0, 5'd0);

    // store immediate, rs2 hazard
    tick();
    settle();
    check("sw_instr", o_instruct, SW_2_M4_1);
    check("sw_imm_s", o_imm, 32'hFFFF_FFFC);
    check("sw_rs2_addr", {27'b0, o_rs2_addr}, 32'd2);
    drive_ex(1'b1, 5'd2);
    settle();
    check("sw_lu_rs2", {31'b0, o_load_use}, 32'd1);
    drive_ex(1'b0, 5'd0);

    // lui: rs1 field is immediate, no hazard on it
    drive_fetch(32'h208, LUI_5, 1'b0);
    tick();
    drive_ex(1'b1, 5'd10);
    settle();
    check("lui_no_lu", {31'b0, o_load_use}, 32'd0);
    check("lui_imm_u", o_imm, 32'h1234_5000);
    check("lui_valid", {31'b0, o_valid}, 32'd1);
    drive_ex(1'b0, 5'd0);

    // branch then flush (with a simultaneous load-use)
    drive_fetch(32'h20C, BEQ_1_2_8, 1'b1);
    tick();
    settle();
    check("beq_imm_b", o_imm, 32'h0000_0008);
    check("beq_pred", {31'b0, o_prediction}, 32'd1);
    flush = 1'b1;
    drive_ex(1'b1, 5'd1);
    drive_fetch(32'h214, JAL_1_M4, 1'b0);
    settle();
    check("flush_lu_flag", {31'b0, o_load_use}, 32'd1);
    check("flush_lu_pc_en", {31'b0, o_pc_enable}, 32'd1);
    tick();
    flush = 1'b0;
    drive_ex(1'b0, 5'd0);
    settle();
    check("flush_instr", o_instruct, NOP);
    check("flush_valid", {31'b0, o_valid}, 32'd0);
    check("flush_pc_cur", o_pc_cur, 32'h0);
    check("flush_pc_four", o_pc_four, 32'h0);
    check("flush_pred", {31'b0, o_prediction}, 32'd0);

    // jal x1,-4
    tick();
    settle();
    check("jal_instr", o_instruct, JAL_1_M4);
    check("jal_imm_j", o_imm, 32'hFFFF_FFFC);
    check("jal_rd_addr", {27'b0, o_rd_addr}, 32'd1);

    // back-to-back stream, latency 1
    stream_tbl[0] = ADD_1_5_0;
    stream_tbl[1] = ADDI_2_7;
    stream_tbl[2] = NOP;
    stream_tbl[3] = LUI_5;
    for (int i = 0; i < 4; i++) begin
      drive_fetch(32'h300 + 32'(i * 4), stream_tbl[i], 1'b0);
      exp_q.push_back(stream_tbl[i]);
      tick();
      settle();
      check("stream_instr", o_instruct, exp_q.pop_front());
      check("stream_pc", o_pc_cur, 32'h300 + 32'(i * 4));
    end

    // reset mid-stream, write on reset cycle discarded
    drive_fetch(32'h400, ADD_1_5_6, 1'b1);
    drive_wb(1'b1, 5'd6, 32'h0000_AAAA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_wb(1'b0, 5'd0, 32'h0);
    settle();
    check("mrst_instr", o_instruct, NOP);
    check("mrst_valid", {31'b0, o_valid}, 32'd0);
    check("mrst_pc_cur", o_pc_cur, 32'h0);
    check("mrst_pred", {31'b0, o_prediction}, 32'd0);
    check("mrst_pc_en", {31'b0, o_pc_enable}, 32'd1);
    tick();
    settle();
    check("mrst_reload", o_instruct, ADD_1_5_6);
    check("mrst_x5_clear", o_rs1_data, 32'h0);
    check("mrst_x6_dropped", o_rs2_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter BYPASS_EN, default 1, SHALL select write-back-to-read bypass in the register file (0 = no bypass).
REQ-002 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 i_pc_cur, i_pc_four, i_instruct  input  32 each  SHALL carry the fetch-stage PC, PC+4 and instruction word.
REQ-005 i_prediction  input  1  SHALL carry the fetch-stage branch prediction bit.
REQ-006 i_stall  input  1  SHALL hold the IF/ID register when high (external stall).
REQ-007 i_flush  input  1  SHALL squash the IF/ID register when high (mispredict redirect).
REQ-008 i_rd_wren  input  1, i_rd_addr  input  5, i_rd_data  input  32  SHALL form the write-back port.
REQ-009 i_ex_mem_rden  input  1, i_ex_rd_addr  input  5  SHALL identify a load currently in EX.
REQ-010 o_pc_cur, o_pc_four, o_instruct  output  32 each, o_prediction  output  1  SHALL present the registered IF/ID contents.
REQ-011 o_rs1_addr, o_rs2_addr, o_rd_addr  output  5 each  SHALL be instruction fields [19:15], [24:20], [11:7].
REQ-012 o_rs1_data, o_rs2_data, o_imm  output  32 each  SHALL be the register operands and sign-extended immediate.
REQ-013 o_valid  output  1  SHALL mark the decoded instruction valid for ID/EX capture.
REQ-014 o_pc_enable  output  1  SHALL drive the fetch-stage PC enable.
REQ-015 o_load_use  output  1  SHALL flag a detected load-use hazard.

Function
REQ-016 The IF/ID register SHALL update with priority: reset > i_flush > hold (i_stall | load_use) > load.
REQ-017 Load: fetch inputs captured, valid = 1; outputs appear exactly one cycle after the fetch inputs (latency 1).
REQ-018 Flush: o_instruct = 32'h0000_0013 (NOP), o_valid = 0, o_prediction = 0, PCs = 0 from the next cycle.
REQ-019 Hold: all IF/ID fields retain their values.
REQ-020 rs1 SHALL count as used for all opcodes except LUI, AUIPC, JAL; rs2 only for R, STORE, BRANCH.
REQ-021 load_use = i_ex_mem_rden & valid & (i_ex_rd_addr != 0) & (i_ex_rd_addr matches a used rs1/rs2), combinational.
REQ-022 o_valid = valid & ~load_use; the same instruction re-issues next cycle once the hazard clears.
REQ-023 o_pc_enable = ~i_stall & (~load_use | i_flush); i_flush together with load_use SHALL resolve as flush.
REQ-024 Register file: 32 x 32 bits, combinational read, write on rising edge when i_rd_wren and i_rd_addr != 0.
REQ-025 Register x0 SHALL always read 0; writes to x0 SHALL be ignored.
REQ-026 When BYPASS_EN = 1, i_rd_wren = 1 and i_rd_addr equals a nonzero rs address, that read SHALL return i_rd_data in the same cycle.
REQ-027 Immediates SHALL follow RV32I I, S, B, U, J formats, sign-extended from bit 31; B/J bit 0 = 0; R-type and unknown opcodes SHALL yield 0.
REQ-028 Register-file writes SHALL proceed regardless of stall or flush.

Reset
REQ-029 On i_rst, the IF/ID register SHALL take o_instruct = NOP, PCs = 0, o_prediction = 0, valid = 0.
REQ-030 On i_rst, all 32 registers SHALL clear to 0; a write on the reset cycle SHALL be discarded.
REQ-031 During and after reset with no hazard, o_load_use = 0 and o_pc_enable = ~i_stall.

Structure
REQ-032 Package decode_pkg SHALL hold the RV32I opcode enum, immediate-type enum and the NOP constant.
REQ-033 The register file SHALL be a sub-module named regfile; the IF/ID register, hazard logic and immediate generator stay in decode_stage.

Verification
REQ-034 Write x5 = 32'hDEAD_BEEF, then decode add x1,x5,x0 -> o_rs1_data = 32'hDEAD_BEEF, o_rs2_data = 0.
REQ-035 Same-cycle write x7 = 32'h1234 while decoding addi x2,x7,-1 -> o_rs1_data = 32'h1234, o_imm = 32'hFFFF_FFFF.
REQ-036 Load x3 in EX, ID holds add x4,x3,x3 -> o_load_use = 1, o_valid = 0, o_pc_enable = 0 for one cycle, then the same instruction with o_valid = 1.
REQ-037 Assert i_flush with beq in the pipe -> next cycle o_instruct = 32'h0000_0013, o_valid = 0.
REQ-038 Write x0 = 32'hFFFF_FFFF, then read x0 -> 0; assert i_rst mid-stream -> next cycle all outputs at reset values and x5 reads 0.
REQ-039 Decode jal x1,-4 (32'hFFDF_F0EF) -> o_imm = 32'hFFFF_FFFC, o_rd_addr = 1.
